top_core: RTL and testbench

Single-cycle RV32I integer core (`top`) that is the CPU at the top of the processor design. It executes one instruction per clock from a 32-bit instruction port and performs loads and stores over a shared bidirectional data bus with active-low acknowledges. The external memory system owns byte ordering, and the STDOUT (0xF000_0000) and EXIT (0xFF00_0000) address decoding.

---
 rtl/top_pkg.sv | 56 +++++
 rtl/top_core_regfile.sv | 29 ++
 rtl/top_core.sv | 171 +++++++++++++++++
 tb/tb_top_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared constants, encodings and ALU operation decode for the top_core RV32I core.
package top_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] F3_SB = 2'b00;
   localparam logic [1:0] F3_SH = 2'b01;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   // alt selects SUB/SRA; callers only raise it where funct7 is meaningful
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/top_core_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, x0 reads as zero.
module regfile
   import top_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] regs [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/top_core.sv
// Single-cycle RV32I core with a shared bidirectional data bus.
// Define TOP_MEM_WAIT_EN to honour ACKI_n/ACKD_n wait states; otherwise every cycle retires.
module top_core
   import top_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ACKI_n,
   input  logic            ACKD_n,
   input  logic [XLEN-1:0] IDT,
   input  logic [2:0]      OINT_n,
   output logic [XLEN-1:0] IAD,
   output logic [XLEN-1:0] DAD,
   output logic            MREQ,
   output logic            WRITE,
   output logic [1:0]      SIZE,
   output logic            IACK_n,
   inout  logic [XLEN-1:0] DDT
);

   logic [XLEN-1:0] pc, pc_plus4, next_pc;
   logic [XLEN-1:0] rs1_val, rs2_val, alu_a, alu_b, alu_y, load_val, store_data, wb_data;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   alu_op_e         alu_op;
   logic            rd_we, wb_pc4, is_load, is_store, is_jal, is_jalr, is_branch, taken, stall;
   logic [1:0]      size_sel;

   assign opcode = IDT[6:0];
   assign f3     = IDT[14:12];
   assign imm_i  = {{20{IDT[31]}}, IDT[31:20]};
   assign imm_s  = {{20{IDT[31]}}, IDT[31:25], IDT[11:7]};
   assign imm_b  = {{19{IDT[31]}}, IDT[31], IDT[7], IDT[30:25], IDT[11:8], 1'b0};
   assign imm_u  = {IDT[31:12], 12'b0};
   assign imm_j  = {{11{IDT[31]}}, IDT[31], IDT[19:12], IDT[20], IDT[30:21], 1'b0};

   regfile u_regfile (
      .clk   (clk),
      .rst_n (rst),
      .we    (rd_we && !stall),
      .ra1   (IDT[19:15]),
      .ra2   (IDT[24:20]),
      .wa    (IDT[11:7]),
      .wd    (wb_data),
      .rd1   (rs1_val),
      .rd2   (rs2_val)
   );

   // Anything not matched here (FENCE, SYSTEM, unknown) falls through as a NOP
   always_comb begin
      alu_op    = ALU_ADD;
      alu_a     = rs1_val;
      alu_b     = imm_i;
      rd_we     = 1'b0;
      wb_pc4    = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OPC_LUI:    begin alu_a = '0; alu_b = imm_u; rd_we = 1'b1; end
         OPC_AUIPC:  begin alu_a = pc; alu_b = imm_u; rd_we = 1'b1; end
         OPC_JAL:    begin rd_we = 1'b1; wb_pc4 = 1'b1; is_jal = 1'b1; end
         OPC_JALR:   begin rd_we = 1'b1; wb_pc4 = 1'b1; is_jalr = 1'b1; end
         OPC_BRANCH: is_branch = 1'b1;
         OPC_LOAD:   begin rd_we = 1'b1; is_load = 1'b1; end
         OPC_STORE:  begin alu_b = imm_s; is_store = 1'b1; end
         OPC_OP_IMM: begin
            rd_we  = 1'b1;
            alu_op = alu_decode(f3, IDT[30] && f3 == 3'b101);
         end
         OPC_OP:     begin
            rd_we  = 1'b1;
            alu_b  = rs2_val;
            alu_op = alu_decode(f3, IDT[30]);
         end
         default:    ;
      endcase
   end

   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLL:  alu_y = alu_a << alu_b[4:0];
         ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
         ALU_XOR:  alu_y = alu_a ^ alu_b;
         ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_AND:  alu_y = alu_a & alu_b;
         default:  alu_y = '0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (f3)
         F3_BEQ:  taken = rs1_val == rs2_val;
         F3_BNE:  taken = rs1_val != rs2_val;
         F3_BLT:  taken = $signed(rs1_val) < $signed(rs2_val);
         F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
         F3_BLTU: taken = rs1_val < rs2_val;
         F3_BGEU: taken = rs1_val >= rs2_val;
         default: taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      next_pc = pc_plus4;
      if (is_jal)                      next_pc = pc + imm_j;
      else if (is_branch && taken)     next_pc = pc + imm_b;
      else if (is_jalr)                next_pc = {alu_y[31:1], 1'b0};
   end

   // Memory system already steers the addressed lane onto the low bits of DDT
   always_comb begin
      load_val = DDT;
      case (f3)
         F3_LB:   load_val = {{24{DDT[7]}}, DDT[7:0]};
         F3_LH:   load_val = {{16{DDT[15]}}, DDT[15:0]};
         F3_LW:   load_val = DDT;
         F3_LBU:  load_val = {24'b0, DDT[7:0]};
         F3_LHU:  load_val = {16'b0, DDT[15:0]};
         default: load_val = DDT;
      endcase
   end

   assign wb_data = wb_pc4 ? pc_plus4 : (is_load ? load_val : alu_y);

   always_comb begin
      size_sel   = SIZE_WORD;
      store_data = rs2_val;
      case (f3[1:0])
         F3_SB:   begin size_sel = SIZE_BYTE; store_data = {24'b0, rs2_val[7:0]}; end
         F3_SH:   begin size_sel = SIZE_HALF; store_data = {16'b0, rs2_val[15:0]}; end
         default: ;
      endcase
   end

   // Gated by rst so an asynchronous reset releases the bus immediately
   assign MREQ   = rst && (is_load || is_store);
   assign WRITE  = rst && is_store;
   assign SIZE   = MREQ ? size_sel : SIZE_WORD;
   assign DAD    = alu_y;
   assign DDT    = (MREQ && WRITE) ? store_data : 'z;
   assign IACK_n = 1'b1;
   assign IAD    = pc;

`ifdef TOP_MEM_WAIT_EN
   logic unused_irq;
   assign unused_irq = ^OINT_n;
   assign stall = ACKI_n || (MREQ && ACKD_n);
`else
   logic unused_inputs;
   assign unused_inputs = ^{OINT_n, ACKI_n, ACKD_n};
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        pc <= RESET_PC;
      else if (!stall) pc <= next_pc;
   end

endmodule

// File: tb/tb_top_core.sv
// Scoreboard bench for top_core: fetch-address trace and store-bus checks against hand-computed values.
module tb_top_core;
   import top_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] data;
   } store_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ACKI_n;
   logic        ACKD_n;
   logic        ackd_hold = 1'b0;
   logic [31:0] IDT;
   logic [2:0]  OINT_n;
   logic [31:0] IAD, DAD;
   logic        MREQ, WRITE, IACK_n;
   logic [1:0]  SIZE;
   wire  [31:0] DDT;
   logic [31:0] bench_data;

   logic [31:0] imem [0:63];
   logic [31:0] exp_iad [$];
   store_t      exp_st [$];
   logic        trace_on = 1'b0;
   int          num_checks = 0;
   int          num_errors = 0;

   top_core dut (
      .clk    (clk),
      .rst    (rst),
      .ACKI_n (ACKI_n),
      .ACKD_n (ACKD_n),
      .IDT    (IDT),
      .OINT_n (OINT_n),
      .IAD    (IAD),
      .DAD    (DAD),
      .MREQ   (MREQ),
      .WRITE  (WRITE),
      .SIZE   (SIZE),
      .IACK_n (IACK_n),
      .DDT    (DDT)
   );

   always #5 clk = ~clk;

   assign IDT    = imem[IAD[7:2]];
   assign ACKD_n = ackd_hold;

   // Memory side of the shared bus: load data when the core reads, a marker pattern when idle
   always_comb begin
      bench_data = 32'hCAFE_F00D;
      if (MREQ) begin
         case (DAD)
            32'h0000_1000: bench_data = 32'h0000_0080;
            32'h0000_1004: bench_data = 32'h0000_8001;
            32'h0000_1008: bench_data = 32'hDEAD_BEEF;
            default:       bench_data = 32'h0000_0000;
         endcase
      end
   end
   assign DDT = (MREQ && WRITE) ? 32'hz : bench_data;

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], OPC_OP};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], OPC_STORE};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], OPC_BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus();
      logic [31:0] trace [$];
      for (int i = 0; i < 64; i++) imem[i] = enc_i(0, 0, 3'b000, 0, OPC_OP_IMM);
      imem['h00 >> 2] = enc_i(5, 0, 3'b000, 1, OPC_OP_IMM);            // addi x1,x0,5
      imem['h04 >> 2] = enc_r(7'b0, 1, 1, 3'b000, 2);                   // add x2,x1,x1
      imem['h08 >> 2] = {20'h08000, 5'd3, OPC_LUI};                     // lui x3,0x08000
      imem['h0C >> 2] = enc_s(0, 2, 3, 3'b010);                         // sw x2,0(x3)
      imem['h10 >> 2] = enc_i(1, 4, 3'b000, 4, OPC_OP_IMM);            // addi x4,x4,1
      imem['h14 >> 2] = enc_i(2, 0, 3'b000, 5, OPC_OP_IMM);            // addi x5,x0,2
      imem['h18 >> 2] = enc_b(32'hFFFF_FFF8, 5, 4, F3_BLT);             // blt x4,x5,-8
      imem['h20 >> 2] = enc_j(16, 1);                                   // jal x1,+16
      imem['h24 >> 2] = {20'hF0000, 5'd6, OPC_LUI};                     // lui x6,0xF0000
      imem['h28 >> 2] = enc_i(32'h41, 0, 3'b000, 7, OPC_OP_IMM);       // addi x7,x0,0x41
      imem['h2C >> 2] = enc_j(20, 0);                                   // jal x0,+20
      imem['h30 >> 2] = enc_s(4, 1, 3, 3'b010);                         // sw x1,4(x3)
      imem['h34 >> 2] = enc_i(1, 1, 3'b000, 0, OPC_JALR);               // jalr x0,1(x1)
      imem['h40 >> 2] = enc_s(0, 7, 6, 3'b000);                         // sb x7,0(x6)
      imem['h44 >> 2] = {20'h00001, 5'd8, OPC_LUI};                     // lui x8,0x1
      imem['h48 >> 2] = enc_i(0, 8, F3_LB, 9, OPC_LOAD);                // lb x9,0(x8)
      imem['h4C >> 2] = enc_i(0, 8, F3_LBU, 10, OPC_LOAD);              // lbu x10,0(x8)
      imem['h50 >> 2] = enc_i(4, 8, F3_LH, 11, OPC_LOAD);               // lh x11,4(x8)
      imem['h54 >> 2] = enc_s(8, 9, 3, 3'b010);                         // sw x9,8(x3)
      imem['h58 >> 2] = enc_s(12, 10, 3, 3'b010);                       // sw x10,12(x3)
      imem['h5C >> 2] = enc_s(16, 11, 3, 3'b010);                       // sw x11,16(x3)
      imem['h60 >> 2] = enc_i(8, 8, F3_LW, 12, OPC_LOAD);               // lw x12,8(x8)
      imem['h64 >> 2] = enc_s(20, 12, 3, 3'b001);                       // sh x12,20(x3)
      imem['h68 >> 2] = enc_r(7'b0100000, 12, 0, 3'b000, 13);           // sub x13,x0,x12
      imem['h6C >> 2] = enc_i(32'h404, 12, 3'b101, 14, OPC_OP_IMM);     // srai x14,x12,4
      imem['h70 >> 2] = enc_s(24, 13, 3, 3'b010);                       // sw x13,24(x3)
      imem['h74 >> 2] = enc_s(28, 14, 3, 3'b010);                       // sw x14,28(x3)
      imem['h78 >> 2] = enc_j(0, 0);                                    // jal x0,0

      trace = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h10, 32'h14,
                32'h18, 32'h1C, 32'h20, 32'h30, 32'h34, 32'h24, 32'h28, 32'h2C, 32'h40,
                32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60};
      foreach (trace[i]) exp_iad.push_back(trace[i]);
`ifdef TOP_MEM_WAIT_EN
      exp_iad.push_back(32'h60);
      exp_iad.push_back(32'h60);
`endif
      trace = '{32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78, 32'h78};
      foreach (trace[i]) exp_iad.push_back(trace[i]);

      exp_st.push_back('{32'h0800_0000, SIZE_WORD, 32'h0000_000A});
      exp_st.push_back('{32'h0800_0004, SIZE_WORD, 32'h0000_0024});
      exp_st.push_back('{32'hF000_0000, SIZE_BYTE, 32'h0000_0041});
      exp_st.push_back('{32'h0800_0008, SIZE_WORD, 32'hFFFF_FF80});
      exp_st.push_back('{32'h0800_000C, SIZE_WORD, 32'h0000_0080});
      exp_st.push_back('{32'h0800_0010, SIZE_WORD, 32'hFFFF_8001});
      exp_st.push_back('{32'h0800_0014, SIZE_HALF, 32'h0000_BEEF});
      exp_st.push_back('{32'h0800_0018, SIZE_WORD, 32'h2152_4111});
      exp_st.push_back('{32'h0800_001C, SIZE_WORD, 32'hFDEA_DBEE});
   endtask

   // Fetch monitor: one expected IAD per cycle once the core is out of reset
   always @(negedge clk) begin
      if (trace_on && exp_iad.size() > 0) checkOutput("iad_trace", IAD, exp_iad.pop_front());
   end

   // Store monitor: every completing write bus cycle is matched against the scoreboard
   always @(negedge clk) begin
      store_t exp;
      if (rst && MREQ && WRITE && !ACKI_n && !ACKD_n) begin
         if (exp_st.size() == 0) begin
            num_checks++;
            num_errors++;
            $display("[TB] FAIL unexpected_store: got addr %08h data %08h, expected no store", DAD, DDT);
         end else begin
            exp = exp_st.pop_front();
            checkOutput("store_dad", DAD, exp.addr);
            checkOutput("store_size", {30'b0, SIZE}, {30'b0, exp.size});
            checkOutput("store_ddt", DDT, exp.data);
         end
      end
   end

`ifdef TOP_MEM_WAIT_EN
   int wait_cnt = 0;
   // Hold the lw at 0x60 for two cycles; address and request must stay put meanwhile
   always @(negedge clk) begin
      if (rst && IAD == 32'h60 && MREQ && !WRITE && wait_cnt < 2) begin
         ackd_hold <= 1'b1;
         wait_cnt++;
         checkOutput("wait_mreq", {31'b0, MREQ}, 32'd1);
         checkOutput("wait_dad", DAD, 32'h0000_1008);
      end else begin
         ackd_hold <= 1'b0;
      end
   end
`endif

   initial begin
      rst    = 1'b0;
      ACKI_n = 1'b0;
      OINT_n = 3'b111;
      applyStimulus();
      repeat (2) @(negedge clk);
      checkOutput("reset_iad", IAD, RESET_PC);
      checkOutput("reset_mreq", {31'b0, MREQ}, 32'd0);
      checkOutput("reset_write", {31'b0, WRITE}, 32'd0);
      checkOutput("reset_size", {30'b0, SIZE}, 32'd0);
      checkOutput("reset_iack_n", {31'b0, IACK_n}, 32'd1);
      checkOutput("reset_ddt_released", DDT, 32'hCAFE_F00D);

      @(posedge clk);
      #1 rst = 1'b1;
      trace_on = 1'b1;

      for (int i = 0; i < 300 && (exp_iad.size() != 0 || exp_st.size() != 0); i++) @(negedge clk);
      checkOutput("program_drain", exp_iad.size() + exp_st.size(), 32'd0);

      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_reset_iad", IAD, RESET_PC);
      checkOutput("async_reset_mreq", {31'b0, MREQ}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
